// File: rtl/jtpopeye_inputs.sv
// ---------------------------------------------------------------------------
// jtpopeye_inputs
//
// Cabinet input conditioner for the Popeye core. Raw frame inputs are
// synchronised, debounced and masked while a ROM download is running. Coin
// presses are queued and turned into fixed-length pulses timed in frames
// (VS rising edges). The pause button acts as a toggle.
//
// Ports
//   clk           system clock (40 MHz)
//   rst_n         asynchronous active-low reset
//   cen           debounce sample strobe, one clk wide
//   VS            game vertical sync, active high, asynchronous
//   downloading   ROM download in progress, masks everything
//   joy1_raw      player 1 {button, up, down, left, right}, active high
//   joy2_raw      player 2, same layout
//   coin_raw      coin slots, active high
//   start_raw     start buttons, active high
//   pause_raw     pause button, active high
//   service_raw   service button, active high
//   joystick1     debounced player 1
//   joystick2     debounced player 2
//   start_button  debounced start buttons
//   coin_input    shaped coin pulse
//   service       debounced service button
//   game_pause_n  1 = run, 0 = paused
//
// Coin FSM states
//   state | meaning
//   IDLE  | no pulse; start one as soon as a coin is pending or arriving
//   PULSE | coin_input high, counting COIN_FRAMES frame ticks
//   GAP   | coin_input low, counting COIN_GAP frame ticks before next pulse
// ---------------------------------------------------------------------------
module jtpopeye_inputs #(
    parameter int DEB_LEN     = 8,
    parameter int COIN_FRAMES = 3,
    parameter int COIN_GAP    = 3,
    parameter int COIN_QMAX   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       VS,
    input  logic       downloading,
    input  logic [4:0] joy1_raw,
    input  logic [4:0] joy2_raw,
    input  logic [1:0] coin_raw,
    input  logic [1:0] start_raw,
    input  logic       pause_raw,
    input  logic       service_raw,
    output logic [4:0] joystick1,
    output logic [4:0] joystick2,
    output logic [1:0] start_button,
    output logic       coin_input,
    output logic       service,
    output logic       game_pause_n
);

    // Bit map of the conditioned input bus
    localparam int NB      = 16;
    localparam int B_COIN  = 10;
    localparam int B_START = 12;
    localparam int B_PAUSE = 14;
    localparam int B_SERV  = 15;

    localparam logic [7:0] DEB_TOP    = 8'(DEB_LEN - 1);
    localparam logic [3:0] FRAMES_TOP = 4'(COIN_FRAMES - 1);
    localparam logic [3:0] GAP_TOP    = 4'(COIN_GAP - 1);
    localparam logic [3:0] QMAX       = 4'(COIN_QMAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    logic [NB-1:0] raw_bus;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] deb;
    logic [7:0]    deb_cnt [NB];

    logic          vs1;
    logic          vs2;
    logic          vs_d;
    logic          fr;

    logic [1:0]    deb_coin_d;
    logic [1:0]    coin_rise;
    logic [1:0]    coin_events;
    logic [2:0]    pending;
    logic [3:0]    pend_sum;
    logic [2:0]    pend_next;
    logic          take;
    logic [3:0]    fcnt;
    coin_state_t   state;

    logic          deb_pause_d;
    logic          pause_rise;

    assign raw_bus = {service_raw, pause_raw, start_raw, coin_raw, joy2_raw, joy1_raw};

    // -----------------------------------------------------------------------
    // Two-flop synchronisers; VS gets a third flop for edge detection
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            vs1   <= 1'b0;
            vs2   <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            sync1 <= raw_bus;
            sync2 <= sync1;
            vs1   <= VS;
            vs2   <= vs1;
            vs_d  <= vs2;
        end
    end

    assign fr = vs2 & ~vs_d;

    // -----------------------------------------------------------------------
    // Debounce: a bit must disagree with its debounced value on DEB_LEN
    // consecutive cen samples before the debounced value follows. Any agreeing
    // sample restarts the count. Runs during downloads too, so a button held
    // across the end of a download does not look like a fresh press.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else if (cen) begin
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_TOP) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Plain button outputs, masked during download
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            joystick1    <= '0;
            joystick2    <= '0;
            start_button <= '0;
            service      <= 1'b0;
        end else begin
            joystick1    <= deb[4:0] & {5{~downloading}};
            joystick2    <= deb[9:5] & {5{~downloading}};
            start_button <= deb[B_START+1:B_START] & {2{~downloading}};
            service      <= deb[B_SERV] & ~downloading;
        end
    end

    // -----------------------------------------------------------------------
    // Coin queue. A coin arriving while IDLE with nothing pending starts its
    // pulse in the same cycle it is counted, so the pulse rises one clk after
    // the debounced edge. Increment and decrement of the same cycle are
    // combined before saturating.
    // -----------------------------------------------------------------------
    assign coin_rise   = deb[B_COIN+1:B_COIN] & ~deb_coin_d;
    assign coin_events = {1'b0, coin_rise[0]} + {1'b0, coin_rise[1]};
    assign take        = (state == IDLE) && ((pending != 3'd0) || (coin_events != 2'd0));
    assign pend_sum    = {1'b0, pending} + {2'b00, coin_events} - {3'b000, take};
    assign pend_next   = (pend_sum > QMAX) ? QMAX[2:0] : pend_sum[2:0];

    // Edge history tracks the debouncer even during downloads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_coin_d  <= '0;
            deb_pause_d <= 1'b0;
        end else begin
            deb_coin_d  <= deb[B_COIN+1:B_COIN];
            deb_pause_d <= deb[B_PAUSE];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            fcnt       <= '0;
            coin_input <= 1'b0;
        end else if (downloading) begin
            state      <= IDLE;
            pending    <= '0;
            fcnt       <= '0;
            coin_input <= 1'b0;
        end else begin
            pending <= pend_next;
            case (state)
                IDLE: begin
                    if (take) begin
                        state      <= PULSE;
                        fcnt       <= '0;
                        coin_input <= 1'b1;
                    end
                end
                PULSE: begin
                    if (fr) begin
                        if (fcnt == FRAMES_TOP) begin
                            state      <= GAP;
                            coin_input <= 1'b0;
                            fcnt       <= '0;
                        end else begin
                            fcnt <= fcnt + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (fr) begin
                        if (fcnt == GAP_TOP) begin
                            state <= IDLE;
                            fcnt  <= '0;
                        end else begin
                            fcnt <= fcnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    fcnt       <= '0;
                    coin_input <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Pause toggle, kept directly as the active-low run flag
    // -----------------------------------------------------------------------
    assign pause_rise = deb[B_PAUSE] & ~deb_pause_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            game_pause_n <= 1'b1;
        end else if (downloading) begin
            game_pause_n <= 1'b1;
        end else if (pause_rise) begin
            game_pause_n <= ~game_pause_n;
        end
    end

endmodule

// File: tb/tb_jtpopeye_inputs.sv
`timescale 1ns/1ps
module tb_jtpopeye_inputs;

    localparam int DEB_LEN = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       VS = 1'b0;
    logic       downloading = 1'b0;
    logic [4:0] joy1_raw = '0;
    logic [4:0] joy2_raw = '0;
    logic [1:0] coin_raw = '0;
    logic [1:0] start_raw = '0;
    logic       pause_raw = 1'b0;
    logic       service_raw = 1'b0;
    logic [4:0] joystick1;
    logic [4:0] joystick2;
    logic [1:0] start_button;
    logic       coin_input;
    logic       service;
    logic       game_pause_n;

    int tests = 0;
    int fails = 0;

    int cen_cnt = 0;
    int vs_cnt = 199;
    event vs_rise;

    jtpopeye_inputs #(
        .DEB_LEN    (DEB_LEN),
        .COIN_FRAMES(3),
        .COIN_GAP   (3),
        .COIN_QMAX  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .VS          (VS),
        .downloading (downloading),
        .joy1_raw    (joy1_raw),
        .joy2_raw    (joy2_raw),
        .coin_raw    (coin_raw),
        .start_raw   (start_raw),
        .pause_raw   (pause_raw),
        .service_raw (service_raw),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .start_button(start_button),
        .coin_input  (coin_input),
        .service     (service),
        .game_pause_n(game_pause_n)
    );

    always #12.5 clk = ~clk;

    // cen once every 4 clk
    always @(negedge clk) begin
        cen = (cen_cnt == 0);
        cen_cnt = (cen_cnt + 1) % 4;
    end

    // VS: period 200 clk, high for 8 clk
    always @(negedge clk) begin
        vs_cnt = (vs_cnt == 199) ? 0 : vs_cnt + 1;
        VS = (vs_cnt < 8);
        if (vs_cnt == 0) -> vs_rise;
    end

    // Call right after changing a raw input at a negedge. Returns just after
    // the posedge on which the debounced value changes: the sync stage shows
    // the new level from the 3rd posedge on, then DEB_LEN cen samples.
    task automatic wait_deb_edge();
        int edges;
        int samples;
        edges = 0;
        samples = 0;
        while (samples < DEB_LEN) begin
            @(posedge clk);
            edges++;
            if (edges >= 3 && cen) samples++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (game_pause_n !== 1'b1) begin
            fails++;
            $display("FAIL reset_pause_in_reset: got %b expected 1", game_pause_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        tests++;
        if ({joystick1, joystick2, start_button, coin_input, service} !== 14'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {joystick1, joystick2, start_button, coin_input, service});
        end
        tests++;
        if (game_pause_n !== 1'b1) begin
            fails++;
            $display("FAIL reset_pause: got %b expected 1", game_pause_n);
        end
    endtask

    task automatic test_debounce();
        // glitch of 5 cen samples
        @(negedge clk);
        joy1_raw[0] = 1'b1;
        repeat (20) @(negedge clk);
        joy1_raw[0] = 1'b0;
        repeat (60) @(negedge clk);
        tests++;
        if (joystick1 !== 5'd0) begin
            fails++;
            $display("FAIL deb_glitch: got %b expected 00000", joystick1);
        end
        // held press
        joy1_raw[0] = 1'b1;
        wait_deb_edge();
        #1;
        tests++;
        if (joystick1 !== 5'd0) begin
            fails++;
            $display("FAIL deb_press_early: got %b expected 00000", joystick1);
        end
        @(posedge clk);
        #1;
        tests++;
        if (joystick1 !== 5'b00001) begin
            fails++;
            $display("FAIL deb_press: got %b expected 00001", joystick1);
        end
        repeat (10) @(negedge clk);
        // release
        joy1_raw[0] = 1'b0;
        wait_deb_edge();
        #1;
        tests++;
        if (joystick1 !== 5'b00001) begin
            fails++;
            $display("FAIL deb_release_early: got %b expected 00001", joystick1);
        end
        @(posedge clk);
        #1;
        tests++;
        if (joystick1 !== 5'd0) begin
            fails++;
            $display("FAIL deb_release: got %b expected 00000", joystick1);
        end
    endtask

    task automatic test_single_coin();
        @(vs_rise);
        repeat (20) @(negedge clk);
        coin_raw = 2'b01;
        wait_deb_edge();
        #1;
        tests++;
        if (coin_input !== 1'b0) begin
            fails++;
            $display("FAIL coin_before_rise: got %b expected 0", coin_input);
        end
        @(posedge clk);
        #1;
        tests++;
        if (coin_input !== 1'b1) begin
            fails++;
            $display("FAIL coin_rise: got %b expected 1", coin_input);
        end
        @(negedge clk);
        coin_raw = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            @(vs_rise);
            repeat (2) @(posedge clk);
            #1;
            tests++;
            if (coin_input !== 1'b1) begin
                fails++;
                $display("FAIL coin_high_frame%0d: got %b expected 1", i, coin_input);
            end
            @(posedge clk);
            #1;
            tests++;
            if (coin_input !== ((i < 3) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL coin_after_frame%0d: got %b expected %b", i, coin_input,
                         (i < 3) ? 1'b1 : 1'b0);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            @(vs_rise);
            repeat (3) @(posedge clk);
            #1;
            tests++;
            if (coin_input !== 1'b0) begin
                fails++;
                $display("FAIL coin_gap_frame%0d: got %b expected 0", i, coin_input);
            end
        end
    endtask

    task automatic test_coin_queue();
        int rises;
        int last_fall;
        int gap_idx;
        logic prev;
        rises = 0;
        last_fall = -1;
        gap_idx = 0;
        prev = 1'b0;
        @(vs_rise);
        repeat (20) @(negedge clk);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (cyc < 60)                      coin_raw = 2'b11;
            else if (cyc >= 120 && cyc < 180)  coin_raw = 2'b01;
            else if (cyc >= 240 && cyc < 300)  coin_raw = 2'b01;
            else if (cyc >= 360 && cyc < 420)  coin_raw = 2'b01;
            else                               coin_raw = 2'b00;
            if (coin_input && !prev) begin
                rises++;
                if (last_fall >= 0) begin
                    gap_idx++;
                    tests++;
                    if (cyc - last_fall != 601) begin
                        fails++;
                        $display("FAIL queue_gap%0d: got %0d clk expected 601", gap_idx,
                                 cyc - last_fall);
                    end
                end
            end
            if (!coin_input && prev) last_fall = cyc;
            prev = coin_input;
        end
        tests++;
        if (rises != 4) begin
            fails++;
            $display("FAIL queue_pulses: got %0d expected 4", rises);
        end
        tests++;
        if (coin_input !== 1'b0) begin
            fails++;
            $display("FAIL queue_end_level: got %b expected 0", coin_input);
        end
    endtask

    task automatic press_pause();
        @(negedge clk);
        pause_raw = 1'b1;
        repeat (60) @(negedge clk);
    endtask

    task automatic release_pause();
        @(negedge clk);
        pause_raw = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_pause();
        tests++;
        if (game_pause_n !== 1'b1) begin
            fails++;
            $display("FAIL pause_initial: got %b expected 1", game_pause_n);
        end
        press_pause();
        tests++;
        if (game_pause_n !== 1'b0) begin
            fails++;
            $display("FAIL pause_first_press: got %b expected 0", game_pause_n);
        end
        release_pause();
        tests++;
        if (game_pause_n !== 1'b0) begin
            fails++;
            $display("FAIL pause_first_release: got %b expected 0", game_pause_n);
        end
        press_pause();
        tests++;
        if (game_pause_n !== 1'b1) begin
            fails++;
            $display("FAIL pause_second_press: got %b expected 1", game_pause_n);
        end
        release_pause();
        press_pause();
        release_pause();
        tests++;
        if (game_pause_n !== 1'b0) begin
            fails++;
            $display("FAIL pause_third_press: got %b expected 0", game_pause_n);
        end
        downloading = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (game_pause_n !== 1'b1) begin
            fails++;
            $display("FAIL pause_download_clear: got %b expected 1", game_pause_n);
        end
        repeat (5) @(negedge clk);
        downloading = 1'b0;
        repeat (20) @(negedge clk);
        tests++;
        if (game_pause_n !== 1'b1) begin
            fails++;
            $display("FAIL pause_after_download: got %b expected 1", game_pause_n);
        end
    endtask

    task automatic test_download_mask();
        int waited;
        int highs;
        @(vs_rise);
        repeat (20) @(negedge clk);
        start_raw = 2'b01;
        coin_raw = 2'b01;
        waited = 0;
        while (!coin_input && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (coin_input !== 1'b1) begin
            fails++;
            $display("FAIL dl_coin_start: got %b expected 1 within 200 clk", coin_input);
        end
        tests++;
        if (start_button !== 2'b01) begin
            fails++;
            $display("FAIL dl_start_before: got %b expected 01", start_button);
        end
        // queue one extra coin on slot 1 while the pulse is running
        coin_raw = 2'b11;
        repeat (50) @(negedge clk);
        coin_raw = 2'b01;
        repeat (50) @(negedge clk);
        tests++;
        if (coin_input !== 1'b1) begin
            fails++;
            $display("FAIL dl_coin_mid_pulse: got %b expected 1", coin_input);
        end
        downloading = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (start_button !== 2'b00) begin
            fails++;
            $display("FAIL dl_start_masked: got %b expected 00", start_button);
        end
        tests++;
        if (coin_input !== 1'b0) begin
            fails++;
            $display("FAIL dl_coin_masked: got %b expected 0", coin_input);
        end
        repeat (20) @(negedge clk);
        downloading = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (start_button !== 2'b01) begin
            fails++;
            $display("FAIL dl_start_after: got %b expected 01", start_button);
        end
        highs = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (coin_input) highs++;
        end
        tests++;
        if (highs != 0) begin
            fails++;
            $display("FAIL dl_no_coin_after: got %0d high clk expected 0", highs);
        end
        start_raw = 2'b00;
        coin_raw = 2'b00;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_single_coin();
        test_coin_queue();
        test_pause();
        test_download_mask();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
